// File: rtl/q3fsm_tx.sv
// q3fsm_tx: stimulus transmitter for the serial two-of-three window detector.
// Define Q3FSM_TX_EXPECT_EN to compile in the exp_z / hit_count prediction.
module q3fsm_tx #(
  parameter logic [2:0] FILL_WORD = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] win_data,
  input  logic       win_valid,
  output logic       win_ready,
  output logic       s,
  output logic       w,
  output logic       busy,
  output logic       underrun,
  output logic       exp_z,
  output logic [7:0] hit_count
);

  typedef enum logic [2:0] {
    IDLE, START, BIT0, BIT1, BIT2
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] mem_q [2];
  logic       rd_ptr_q, wr_ptr_q;
  logic [1:0] cnt_q, cnt_d;
  logic [2:0] sh_q;
  logic       und_q;
  logic       load, push, pop;

  assign load      = (state_q == START) || (state_q == BIT2);
  assign win_ready = (cnt_q != 2'd2);
  assign push      = win_valid && win_ready;
  assign pop       = load && (cnt_q != 2'd0);
  assign cnt_d     = cnt_q + {1'b0, push} - {1'b0, pop};

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: once started, the stream cycles forever until reset
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = START;
      START:   state_d = BIT0;
      BIT0:    state_d = BIT1;
      BIT1:    state_d = BIT2;
      BIT2:    state_d = BIT0;
      default: state_d = IDLE;
    endcase
  end

  // Two-entry word FIFO; push and pop may coincide
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= win_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_d;
    end
  end

  // Window shift register loaded on entry to BIT0; fill word on underrun
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q  <= 3'b000;
      und_q <= 1'b0;
    end else begin
      und_q <= load && (cnt_q == 2'd0);
      if (load) sh_q <= pop ? mem_q[rd_ptr_q] : FILL_WORD;
    end
  end

  // Outputs decoded from registered state
  always_comb begin
    s        = (state_q == START);
    busy     = (state_q != IDLE);
    underrun = und_q;
    w        = 1'b0;
    unique case (state_q)
      BIT0:    w = sh_q[0];
      BIT1:    w = sh_q[1];
      BIT2:    w = sh_q[2];
      default: w = 1'b0;
    endcase
  end

`ifdef Q3FSM_TX_EXPECT_EN
  logic       ez_q;
  logic [7:0] hit_q;
  logic       zhit;

  assign zhit = (state_q == BIT2) &&
                ((sh_q == 3'b011) || (sh_q == 3'b101) ||
                 (sh_q == 3'b110));

  // Predicted z lands in the BIT0 cycle after the window; hits saturate
  always_ff @(posedge clk) begin
    if (reset) begin
      ez_q  <= 1'b0;
      hit_q <= 8'h00;
    end else begin
      ez_q <= zhit;
      if (zhit && (hit_q != 8'hFF)) hit_q <= hit_q + 8'h01;
    end
  end

  assign exp_z     = ez_q;
  assign hit_count = hit_q;
`else
  assign exp_z     = 1'b0;
  assign hit_count = 8'h00;
`endif

endmodule
